// File: rtl/host_device_bus.sv
// ---------------------------------------------------------------------------
// host_device_bus
//   Single-layer interconnect joining NrHosts bus masters to NrDevices
//   memory-mapped slaves. The request path is purely combinational: a
//   fixed-priority arbiter (lowest host index wins) picks one host, and its
//   address is decoded against per-device base/mask pairs. The response
//   path is registered: the winning host/device pair is captured on the
//   grant edge and used one cycle later to steer the device response back.
//
//   Optional build macro: BUS_UNMAPPED_ERR_EN
//     defined   - an address that matches no region is granted but no device
//                 is requested; the bus answers itself next cycle with
//                 rvalid=1, err=1, rdata=0.
//     undefined - an unmatched address goes to device NrDevices-1, which acts
//                 as the default slave and answers normally.
//
// Ports
//   clk_i, rst_ni           clock, async active-low reset
//   host_req_i/gnt_o        per-host request / same-cycle grant
//   host_addr/we/be/wdata_i per-host request payload
//   host_rvalid/rdata/err_o per-host response (one cycle after grant)
//   device_req_o            per-device request (at most one set)
//   device_addr/we/be/wdata_o winner payload broadcast to every device
//   device_rvalid/rdata/err_i per-device response (one cycle after request)
//   cfg_device_addr_base/mask per-device region; quasi-static
// ---------------------------------------------------------------------------

// Region match for one device: address bits under the mask must equal base.
module host_device_bus_dec #(
  parameter int AddressWidth = 32
) (
  input  logic [AddressWidth-1:0] addr,
  input  logic [AddressWidth-1:0] base,
  input  logic [AddressWidth-1:0] mask,
  output logic                    match
);
  assign match = ((addr & mask) == base);
endmodule

module host_device_bus #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,

  input  logic [NrHosts-1:0]                     host_req_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                     host_err_o,

  output logic [NrDevices-1:0]                   device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o,
  output logic [NrDevices-1:0]                   device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]  device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o,
  input  logic [NrDevices-1:0]                   device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i,
  input  logic [NrDevices-1:0]                   device_err_i,

  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask
);

  localparam int HIW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
  localparam int DIW = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  // ---- arbitration -------------------------------------------------------
  logic           any_req;
  logic [HIW-1:0] win_idx;

  // Scan high to low so the lowest requesting index is the last writer.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int i = NrHosts-1; i >= 0; i--) begin
      if (host_req_i[i]) begin
        any_req = 1'b1;
        win_idx = HIW'(i);
      end
    end
  end

  for (genvar h = 0; h < NrHosts; h++) begin : g_gnt
    assign host_gnt_o[h] = any_req && (win_idx == HIW'(h));
  end

  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [DataWidth/8-1:0]  win_be;
  logic [DataWidth-1:0]    win_wdata;

  assign win_addr  = host_addr_i[win_idx];
  assign win_we    = host_we_i[win_idx];
  assign win_be    = host_be_i[win_idx];
  assign win_wdata = host_wdata_i[win_idx];

  // ---- address decode ----------------------------------------------------
  logic [NrDevices-1:0] dev_match;

  for (genvar d = 0; d < NrDevices; d++) begin : g_dec
    host_device_bus_dec #(.AddressWidth(AddressWidth)) u_dec (
      .addr  (win_addr),
      .base  (cfg_device_addr_base[d]),
      .mask  (cfg_device_addr_mask[d]),
      .match (dev_match[d])
    );
  end

  logic           hit;
  logic [DIW-1:0] hit_idx;
  logic [DIW-1:0] tgt_idx;  // device that owns this transaction's response
  logic           tgt_req;  // whether a device port is actually requested

  // Overlapping regions resolve to the lowest device index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int d = NrDevices-1; d >= 0; d--) begin
      if (dev_match[d]) begin
        hit     = 1'b1;
        hit_idx = DIW'(d);
      end
    end
  end

`ifdef BUS_UNMAPPED_ERR_EN
  assign tgt_idx = hit_idx;
  assign tgt_req = hit;
`else
  // Misses fall through to the last device, which serves as default slave.
  assign tgt_idx = hit ? hit_idx : DIW'(NrDevices-1);
  assign tgt_req = 1'b1;
`endif

  // ---- request fan-out ---------------------------------------------------
  // Payload is broadcast; only device_req_o qualifies it.
  for (genvar d = 0; d < NrDevices; d++) begin : g_dev
    assign device_req_o[d]   = any_req && tgt_req && (tgt_idx == DIW'(d));
    assign device_addr_o[d]  = win_addr;
    assign device_we_o[d]    = win_we;
    assign device_be_o[d]    = win_be;
    assign device_wdata_o[d] = win_wdata;
  end

  // ---- response steering register ---------------------------------------
  logic           rsp_vld_q;
  logic [HIW-1:0] host_q;
  logic [DIW-1:0] dev_q;
`ifdef BUS_UNMAPPED_ERR_EN
  logic           miss_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_q <= 1'b0;
      host_q    <= '0;
      dev_q     <= '0;
`ifdef BUS_UNMAPPED_ERR_EN
      miss_q    <= 1'b0;
`endif
    end else begin
      rsp_vld_q <= any_req;
      if (any_req) begin
        host_q <= win_idx;
        dev_q  <= tgt_idx;
`ifdef BUS_UNMAPPED_ERR_EN
        miss_q <= !hit;
`endif
      end
    end
  end

  // ---- response path -----------------------------------------------------
  // Only the host granted last cycle sees device signals; everyone else is
  // held at zero so stray device activity never leaks to an idle host.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (rsp_vld_q && (host_q == HIW'(h))) begin
`ifdef BUS_UNMAPPED_ERR_EN
        if (miss_q) begin
          host_rvalid_o[h] = 1'b1;
          host_err_o[h]    = 1'b1;
        end else begin
`else
        begin
`endif
          host_rvalid_o[h] = device_rvalid_i[dev_q];
          host_err_o[h]    = device_err_i[dev_q];
          host_rdata_o[h]  = device_rdata_i[dev_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_host_device_bus.sv
// ---------------------------------------------------------------------------
// tb_host_device_bus
//   Directed scenarios for the documented cases followed by randomized
//   traffic. Expected values come from a transaction-level model: each cycle
//   the model computes the winner and target from the arbitration/decode
//   rules and remembers which host expects a response next cycle.
// ---------------------------------------------------------------------------
module tb_host_device_bus;
  localparam int NH = 2, ND = 3, DW = 32, AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NH-1:0]               host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [NH-1:0][AW-1:0]       host_addr;
  logic [NH-1:0][DW/8-1:0]     host_be;
  logic [NH-1:0][DW-1:0]       host_wdata, host_rdata;
  logic [ND-1:0]               dev_req, dev_we, dev_rvalid, dev_err;
  logic [ND-1:0][AW-1:0]       dev_addr, cfg_base, cfg_mask;
  logic [ND-1:0][DW/8-1:0]     dev_be;
  logic [ND-1:0][DW-1:0]       dev_wdata, dev_rdata;

  host_device_bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .device_req_o(dev_req), .device_addr_o(dev_addr), .device_we_o(dev_we),
    .device_be_o(dev_be), .device_wdata_o(dev_wdata), .device_rvalid_i(dev_rvalid),
    .device_rdata_i(dev_rdata), .device_err_i(dev_err),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model state: the response owed next cycle.
  bit p_vld, p_miss, nx_vld, nx_miss;
  int p_host, p_dev, nx_host, nx_dev;

  function automatic int decode(input logic [AW-1:0] a);
    for (int d = 0; d < ND; d++)
      if ((a & cfg_mask[d]) == cfg_base[d]) return d;
    return -1;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 32'h0010_0000 + $urandom_range(0, 32'hF_FFFF);
      1: return 32'h0002_0000 + $urandom_range(0, 32'h3FF);
      2: return 32'h0003_0000 + $urandom_range(0, 32'h3FF);
      3: return 32'h0005_0000 + $urandom_range(0, 32'hFF);
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_dev();
    for (int d = 0; d < ND; d++) begin
      dev_rvalid[d] = 1'($urandom);
      dev_err[d]    = 1'($urandom);
      dev_rdata[d]  = $urandom;
    end
  endtask

  task automatic set_dev(input int d, input logic v, input logic [DW-1:0] data, input logic e);
    dev_rvalid[d] = v; dev_rdata[d] = data; dev_err[d] = e;
  endtask

  task automatic set_host(input int h, input logic r, input logic [AW-1:0] a,
                          input logic we, input logic [DW-1:0] wd);
    host_req[h] = r; host_addr[h] = a; host_we[h] = we;
    host_be[h] = 4'hF; host_wdata[h] = wd;
  endtask

  // Compare all outputs against the model for the current (settled) inputs.
  task automatic check_cycle();
    int w, d, tgt;
    logic ev, ee;
    logic [DW-1:0] ed;
    w = -1;
    for (int i = 0; i < NH; i++) if (host_req[i] && w < 0) w = i;
    for (int i = 0; i < NH; i++) chk($sformatf("gnt%0d", i), 64'(host_gnt[i]), 64'(i == w));
    d = (w >= 0) ? decode(host_addr[w]) : -1;
`ifdef BUS_UNMAPPED_ERR_EN
    tgt = d;
`else
    tgt = (d < 0) ? ND-1 : d;
`endif
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("dreq%0d", k), 64'(dev_req[k]), 64'((w >= 0) && (tgt == k)));
      if (w >= 0) begin
        chk($sformatf("daddr%0d", k), 64'(dev_addr[k]), 64'(host_addr[w]));
        chk($sformatf("dwe%0d", k), 64'(dev_we[k]), 64'(host_we[w]));
        chk($sformatf("dbe%0d", k), 64'(dev_be[k]), 64'(host_be[w]));
        chk($sformatf("dwdata%0d", k), 64'(dev_wdata[k]), 64'(host_wdata[w]));
      end
    end
    for (int h = 0; h < NH; h++) begin
      ev = 1'b0; ee = 1'b0; ed = '0;
      if (p_vld && p_host == h) begin
        if (p_miss) begin ev = 1'b1; ee = 1'b1; end
        else begin ev = dev_rvalid[p_dev]; ee = dev_err[p_dev]; ed = dev_rdata[p_dev]; end
      end
      chk($sformatf("rvalid%0d", h), 64'(host_rvalid[h]), 64'(ev));
      chk($sformatf("rerr%0d", h), 64'(host_err[h]), 64'(ee));
      chk($sformatf("rdata%0d", h), 64'(host_rdata[h]), 64'(ed));
    end
    nx_vld = (w >= 0);
    nx_host = w;
    nx_dev = tgt;
`ifdef BUS_UNMAPPED_ERR_EN
    nx_miss = (w >= 0) && (d < 0);
`else
    nx_miss = 1'b0;
`endif
  endtask

  // Called at a negedge with inputs driven; ends at the next negedge.
  task automatic cyc();
    #1 check_cycle();
    @(posedge clk);
    if (!rst_n) p_vld = 1'b0;
    else begin p_vld = nx_vld; p_host = nx_host; p_dev = nx_dev; p_miss = nx_miss; end
    @(negedge clk);
  endtask

  task automatic idle_hosts();
    for (int h = 0; h < NH; h++) set_host(h, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    p_vld = 1'b0; p_miss = 1'b0; p_host = 0; p_dev = 0;
    idle_hosts();
    rand_dev();

    // Reset state: responses quiet even with device inputs toggling.
    @(negedge clk);
    cyc();
    chk("rst_rvalid", 64'(host_rvalid), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Write to device 0.
    set_host(0, 1'b1, 32'h0010_0010, 1'b1, 32'hDEAD_BEEF);
    cyc();
    // Read device 1; write response and read request overlap here.
    set_host(0, 1'b1, 32'h0002_0008, 1'b0, '0);
    set_dev(0, 1'b1, 32'h0, 1'b0);
    cyc();
    idle_hosts();
    set_dev(1, 1'b1, 32'h1234_5678, 1'b0);
    #1 chk("rd_dev1_data", 64'(host_rdata[0]), 64'h1234_5678);
    cyc();

    // Back-to-back reads to device 0 then device 2, second one errors.
    set_host(0, 1'b1, 32'h0010_0000, 1'b0, '0);
    cyc();
    set_host(0, 1'b1, 32'h0003_0004, 1'b0, '0);
    set_dev(0, 1'b1, 32'hAAAA_0000, 1'b0);
    cyc();
    idle_hosts();
    set_dev(2, 1'b1, 32'hBBBB_2222, 1'b1);
    #1 chk("b2b_err", 64'(host_err[0]), 64'(1));
    cyc();

    // Two hosts contend: host 0 wins, then host 1 once host 0 drops.
    set_host(0, 1'b1, 32'h0002_0000, 1'b0, '0);
    set_host(1, 1'b1, 32'h0003_0000, 1'b0, '0);
    #1 chk("arb_h1_gnt", 64'(host_gnt[1]), 64'(0));
    cyc();
    host_req[0] = 1'b0;
    set_dev(1, 1'b1, 32'h0101_0101, 1'b0);
    cyc();
    idle_hosts();
    set_dev(2, 1'b1, 32'h0202_0202, 1'b0);
    cyc();

    // Unmapped address.
    set_host(1, 1'b1, 32'h0005_0000, 1'b0, '0);
`ifdef BUS_UNMAPPED_ERR_EN
    #1 chk("unmapped_noreq", 64'(dev_req), 64'(0));
`else
    #1 chk("unmapped_dflt", 64'(dev_req), 64'(3'b100));
`endif
    cyc();
    idle_hosts();
    rand_dev();
    cyc();

    // Reset in the cycle after a grant drops the in-flight response.
    set_host(0, 1'b1, 32'h0002_0010, 1'b0, '0);
    cyc();
    idle_hosts();
    set_dev(1, 1'b1, 32'hCAFE_F00D, 1'b0);
    rst_n = 1'b0;
    p_vld = 1'b0;
    #1 chk("rst_flight_rvalid", 64'(host_rvalid), 64'(0));
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_rvalid", 64'(host_rvalid), 64'(0));

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int h = 0; h < NH; h++)
        set_host(h, ($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom), $urandom);
      for (int h = 0; h < NH; h++) host_be[h] = 4'($urandom);
      rand_dev();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/host_device_bus.md
Name: host_device_bus

Overview:
- Combinational-request, registered-response interconnect that connects NrHosts bus masters to NrDevices memory-mapped slaves.
- Provides fixed-priority host arbitration and base/mask address decode.
- Routes each device response back to the issuing host one cycle after the grant.
- Sits between the core data port and the RAM/sim-control/timer devices in the simple system.

Parameters:
- NrDevices, 1, number of device ports (≥1).
- NrHosts, 1, number of host ports (≥1).
- DataWidth, 32, data bus width in bits.
- AddressWidth, 32, address bus width in bits.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset, asynchronous, active-low
- host_req_i  input  [NrHosts] x 1  host request
- host_gnt_o  output  [NrHosts] x 1  host grant
- host_addr_i  input  [NrHosts] x AddressWidth  byte address
- host_we_i  input  [NrHosts] x 1  write enable
- host_be_i  input  [NrHosts] x DataWidth/8  byte enables
- host_wdata_i  input  [NrHosts] x DataWidth  write data
- host_rvalid_o  output  [NrHosts] x 1  response valid
- host_rdata_o  output  [NrHosts] x DataWidth  read data
- host_err_o  output  [NrHosts] x 1  response error
- device_req_o  output  [NrDevices] x 1  device request
- device_addr_o  output  [NrDevices] x AddressWidth  address, forwarded unmodified
- device_we_o  output  [NrDevices] x 1  write enable
- device_be_o  output  [NrDevices] x DataWidth/8  byte enables
- device_wdata_o  output  [NrDevices] x DataWidth  write data
- device_rvalid_i  input  [NrDevices] x 1  device response valid
- device_rdata_i  input  [NrDevices] x DataWidth  device read data
- device_err_i  input  [NrDevices] x 1  device error
- cfg_device_addr_base  input  [NrDevices] x AddressWidth  region base per device
- cfg_device_addr_mask  input  [NrDevices] x AddressWidth  region mask per device

Behaviour:
- Arbitration: combinational, fixed priority; the lowest-index host with host_req_i=1 wins. Exactly that host gets host_gnt_o=1 in the same cycle; all others get 0. No request → no grant.
- Decode: device d matches when (winning addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]. Lowest matching index wins if regions overlap.
- Request path: combinational.
  - Selected device gets device_req_o=1 with the winner's addr/we/be/wdata.
  - Non-selected devices get device_req_o=0; their addr/we/be/wdata are driven with the same winner values (don't-care).
- Devices must accept every request in the cycle presented (no device-side grant). Devices must return device_rvalid_i exactly one cycle later.
- Response path: on each granted cycle, host index, device index and a miss flag are registered.
  - Next cycle, the registered host gets host_rvalid_o = device_rvalid_i[dev_q], host_rdata_o = device_rdata_i[dev_q] and host_err_o = device_err_i[dev_q].
  - Non-registered hosts get rvalid=0, err=0, rdata=0.
- Pipelining: a new grant is allowed every cycle, back-to-back, including a different host or device while the previous response returns.
- No grant in cycle N → all host_rvalid_o=0 in cycle N+1.
- Reset (async, rst_ni=0): registered selection cleared to "no pending response". All host_rvalid_o/host_err_o=0 and host_rdata_o=0 during and immediately after reset. A request in flight at reset is dropped; no response is delivered.
- Config inputs are quasi-static; a change takes effect on the next decode.

Optional Feature:
- Macro BUS_UNMAPPED_ERR_EN.
- Defined: a decode miss is still granted but drives no device_req_o. Next cycle the bus itself returns host_rvalid_o=1, host_err_o=1, host_rdata_o=0.
- Undefined: a decode miss is routed to device NrDevices-1 as default device. Its response is returned normally.

Test Plan:
- Config NrHosts=1, NrDevices=3, bases 0x100000/0x20000/0x30000, masks ~0xFFFFF/~0x3FF/~0x3FF. Host write 0x100010, data 0xDEADBEEF, be=0xF → same cycle gnt=1, device_req[0]=1 with addr 0x100010; other device_reqs=0.
- Read 0x20008; device 1 returns rdata 0x12345678 next cycle → host_rvalid=1, host_rdata=0x12345678, err=0 exactly one cycle after the grant.
- Back-to-back reads 0x100000 then 0x30004 on consecutive cycles → two consecutive rvalids with device 0 data then device 2 data. Device 2 err=1 propagates as host_err=1 on the second response.
- NrHosts=2, both request in the same cycle → host 0 granted, host 1 gnt=0. Next cycle only host 0 gets rvalid. Host 1 is granted once host 0 drops req.
- Read 0x50000 (unmapped) with BUS_UNMAPPED_ERR_EN → gnt=1, no device_req, next cycle rvalid=1, err=1, rdata=0. Without the macro → device_req[2]=1.
- Assert rst_ni=0 in the cycle after a grant → host_rvalid stays 0 and no response is delivered after reset release.
